des_subkey_scheduler: RTL and testbench
=======================================

DES_SUBKEY_SCHEDULER -- requirements
Module: des_subkey_scheduler

Interface
REQ-001 SHALL have no parameters; all widths are fixed by FIPS 46-3.
REQ-002 SHALL have port wClock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port wReset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wStart  input  1  request a new 16-subkey sequence; sampled only in IDLE.
REQ-005 SHALL have port wDecrypt  input  1  direction, sampled with wStart: 1 = K16..K1 order, 0 = K1..K16 order.
REQ-006 SHALL have port wKey  input  64  DES key; bit 1 (FIPS numbering) = wKey[63]; parity bits 8,16,...,64 ignored.
REQ-007 SHALL have port wReady  input  1  downstream Feistel datapath accepts wSubkey this cycle.
REQ-008 SHALL have port wSubkey  output  48  current round subkey, PC-2 output; FIPS bit 1 = wSubkey[47].
REQ-009 SHALL have port wSubkeyValid  output  1  wSubkey and wRoundIndex are valid.
REQ-010 SHALL have port wRoundIndex  output  4  round number of the current subkey minus 1 (0 = K1, 15 = K16).
REQ-011 SHALL have port wBusy  output  1  high in RUN.
REQ-012 SHALL have port wDone  output  1  one-cycle pulse after the 16th subkey transfer.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with wStart=1, load 28-bit registers C,D from PC-1(wKey), latch wDecrypt, and enter RUN.
REQ-015 SHALL use the FIPS shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 SHALL, in encrypt mode, form subkey Ki = PC-2(ROL(C,s[i]), ROL(D,s[i])) with C,D holding C(i-1),D(i-1), for i = 1..16.
REQ-017 SHALL, in decrypt mode, present K16 = PC-2(C0,D0) first, then after each transfer of Ki rotate C,D right by s[i] and present K(i-1).
REQ-018 SHALL register wSubkey, wSubkeyValid and wRoundIndex; the first subkey is valid the cycle after wStart is accepted (latency 1).
REQ-019 SHALL count a transfer only on a cycle with wSubkeyValid=1 and wReady=1.
REQ-020 SHALL present the next subkey on the cycle after a transfer, with no bubble, so 16 back-to-back transfers take 16 cycles.
REQ-021 SHALL hold wSubkey, wRoundIndex and wSubkeyValid stable while wSubkeyValid=1 and wReady=0, for any stall length.
REQ-022 SHALL, on the 16th transfer, deassert wSubkeyValid next cycle, enter DONE, assert wDone for exactly one cycle, then return to IDLE.
REQ-023 SHALL ignore wStart in RUN and DONE; no restart or queueing.
REQ-024 SHALL ignore changes on wKey and wDecrypt after the wStart cycle.
REQ-025 SHALL end with C,D rotated by 28 total positions in either mode, equal to PC-1(wKey); an assertion checks this at DONE.
REQ-026 SHALL, with wStart=1 on the DONE cycle, not start; a new start is accepted only in IDLE, the cycle after DONE at the earliest.
REQ-027 SHALL drive wSubkeyValid=0 outside RUN; wSubkey holds its last value and is don't-care when invalid.

Reset
REQ-028 SHALL, with wReset=1 at a clock edge, enter IDLE and clear to 0: C, D, wSubkey, wSubkeyValid, wRoundIndex, wBusy, wDone, and the latched mode.
REQ-029 SHALL give wReset priority over wStart and wReady on the same edge, including reset mid-RUN; the partial sequence is abandoned and wDone is not asserted.

Verification
REQ-030 Bench SHALL cover encrypt mode: wKey=64'h133457799BBCDFF1, wDecrypt=0, wReady=1 -> first subkey 48'h1B02EFFC7072 with index 0; 16th subkey 48'hCB3D8B0E17F5 with index 15; wDone the following cycle.
REQ-031 Bench SHALL cover decrypt mode: same key, wDecrypt=1 -> first subkey 48'hCB3D8B0E17F5 with index 15; last subkey 48'h1B02EFFC7072 with index 0; the full sequence equals the encrypt sequence reversed.
REQ-032 Bench SHALL cover backpressure: decrypt run with wReady randomly 0 for up to 5 cycles -> outputs stable during stalls, exactly 16 transfers, wDone exactly once.
REQ-033 Bench SHALL cover reset mid-run: wReset=1 after the 7th transfer -> all outputs 0 next cycle; a fresh wStart then yields the full correct 16-subkey sequence.
REQ-034 Bench SHALL cover ignored start: wStart pulsed during RUN with a different wKey -> sequence unaffected; parity-bit-only key change (flip wKey[0]) -> identical subkeys.

Source files
------------

// File: rtl/des_subkey_scheduler.sv
// des_subkey_scheduler
// Produces the sixteen 48-bit DES round subkeys (FIPS 46-3 key schedule),
// one per accepted transfer. The subkeys come out in K1..K16 order for
// encryption or K16..K1 order for decryption. The outputs use a
// valid/ready handshake toward the Feistel datapath.
//
// Ports
//   wClock       : clock; all state changes on the rising edge
//   wReset       : synchronous active-high reset
//   wStart       : begin a new subkey sequence (honoured only in IDLE)
//   wDecrypt     : direction, latched with wStart (1 = K16 first)
//   wKey[63:0]   : DES key, FIPS bit 1 = wKey[63], parity bits ignored
//   wReady       : downstream accepts wSubkey this cycle
//   wSubkey[47:0]: current round subkey, FIPS bit 1 = wSubkey[47]
//   wSubkeyValid : wSubkey / wRoundIndex are valid
//   wRoundIndex  : round number minus 1 of the presented subkey
//   wBusy        : sequence in progress
//   wDone        : one-cycle pulse after the 16th transfer
module des_subkey_scheduler (
  input  logic        wClock,
  input  logic        wReset,
  input  logic        wStart,
  input  logic        wDecrypt,
  input  logic [63:0] wKey,
  input  logic        wReady,
  output logic [47:0] wSubkey,
  output logic        wSubkeyValid,
  output logic [3:0]  wRoundIndex,
  output logic        wBusy,
  output logic        wDone
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic [1:0]  state;
  logic [27:0] c_reg, d_reg;
  logic        mode;
  logic [55:0] pc1_snap;
  logic [55:0] start_cd;
  logic [27:0] c0, d0, c1, d1, c_step, d_step;
  logic [3:0]  idx_next;
  logic        last_xfer;

  // FIPS numbering: table entry n refers to vector bit (width - n).
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = key[6'(64 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return r;
  endfunction

  // Shift amount for 0-based round idx is 1 only for rounds 1, 2, 9 and 16.
  function automatic logic shift_two(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign start_cd = pc1(wKey);
  assign c0       = start_cd[55:28];
  assign d0       = start_cd[27:0];
  assign c1       = rol28(c0, shift_two(4'd0));
  assign d1       = rol28(d0, shift_two(4'd0));

  // C/D always hold the halves belonging to the presented subkey. Encrypt
  // steps forward with the next round's shift; decrypt undoes the current
  // round's shift.
  assign idx_next  = mode ? wRoundIndex - 4'd1 : wRoundIndex + 4'd1;
  assign c_step    = mode ? ror28(c_reg, shift_two(wRoundIndex)) : rol28(c_reg, shift_two(idx_next));
  assign d_step    = mode ? ror28(d_reg, shift_two(wRoundIndex)) : rol28(d_reg, shift_two(idx_next));
  assign last_xfer = mode ? (wRoundIndex == 4'd0) : (wRoundIndex == 4'd15);

  assign wBusy = (state == RUN);
  assign wDone = (state == DONE);

  always_ff @(posedge wClock) begin
    if (wReset) begin
      state        <= IDLE;
      c_reg        <= '0;
      d_reg        <= '0;
      mode         <= 1'b0;
      wSubkey      <= '0;
      wSubkeyValid <= 1'b0;
      wRoundIndex  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wStart) begin
            state        <= RUN;
            mode         <= wDecrypt;
            wSubkeyValid <= 1'b1;
            if (wDecrypt) begin
              // C16/D16 equal C0/D0, so K16 comes straight from PC-1.
              c_reg       <= c0;
              d_reg       <= d0;
              wSubkey     <= pc2({c0, d0});
              wRoundIndex <= 4'd15;
            end else begin
              c_reg       <= c1;
              d_reg       <= d1;
              wSubkey     <= pc2({c1, d1});
              wRoundIndex <= 4'd0;
            end
          end
        end
        RUN: begin
          if (wReady) begin
            if (last_xfer) begin
              state        <= DONE;
              wSubkeyValid <= 1'b0;
              // Decrypt owes one final right rotation to return to C0/D0.
              if (mode) begin
                c_reg <= c_step;
                d_reg <= d_step;
              end
            end else begin
              c_reg       <= c_step;
              d_reg       <= d_step;
              wSubkey     <= pc2({c_step, d_step});
              wRoundIndex <= idx_next;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Copy of PC-1(key) at start, used only to confirm the 28-position
  // round trip of C/D when the sequence finishes.
  always_ff @(posedge wClock) begin
    if (!wReset && state == IDLE && wStart)
      pc1_snap <= start_cd;
  end

  always_ff @(posedge wClock) begin
    if (!wReset && state == DONE)
      assert ({c_reg, d_reg} == pc1_snap);
  end

endmodule

// File: tb/tb_des_subkey_scheduler.sv
module tb_des_subkey_scheduler;

  logic        wClock = 1'b0;
  logic        wReset, wStart, wDecrypt, wReady;
  logic [63:0] wKey;
  logic [47:0] wSubkey;
  logic        wSubkeyValid, wBusy, wDone;
  logic [3:0]  wRoundIndex;

  des_subkey_scheduler dut (
    .wClock(wClock), .wReset(wReset), .wStart(wStart), .wDecrypt(wDecrypt),
    .wKey(wKey), .wReady(wReady), .wSubkey(wSubkey), .wSubkeyValid(wSubkeyValid),
    .wRoundIndex(wRoundIndex), .wBusy(wBusy), .wDone(wDone));

  always #5 wClock = ~wClock;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          checks_failed = 0;
  logic [47:0] ks [16];
  logic [47:0] first_sk, last_sk;
  logic [3:0]  first_idx, last_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wClock);
    #1;
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] y;
    int m;
    m = n % 28;
    y = {28'b0, x};
    y = (y << m) | (y >> (28 - m));
    return y[27:0];
  endfunction

  // Ki = PC-2 of C0/D0 rotated left by the cumulative shift through round i.
  task automatic compute_model(input logic [63:0] key);
    logic [55:0] cd, cdr;
    logic [47:0] k;
    int tot;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS[r];
      cdr = {rotl28(cd[55:28], tot), rotl28(cd[27:0], tot)};
      k = '0;
      for (int j = 0; j < 48; j++) k[6'(47 - j)] = cdr[6'(56 - PC2[j])];
      ks[r] = k;
    end
  endtask

  task automatic run_seq(input logic [63:0] drive_key, input logic [63:0] model_key,
                         input logic dec, input bit stall, input bit poke,
                         input int abort_after, input bit restart_at_done);
    int xfers, cyc, stall_left, r, dones_early;
    logic [47:0] psk;
    logic [3:0]  pidx;
    logic        pval;
    bit          pstall;
    compute_model(model_key);
    wKey = drive_key; wDecrypt = dec; wStart = 1'b1; wReady = 1'b1;
    tick();
    wStart = 1'b0;
    check("latency_valid", {wSubkeyValid, wBusy}, 2'b11);
    xfers = 0; cyc = 0; stall_left = 0; pstall = 0; dones_early = 0;
    psk = '0; pidx = '0; pval = 1'b0;
    while (xfers < 16 && cyc < 400) begin
      if (wDone) dones_early++;
      if (pstall) check("stall_hold", {pval, pidx, psk}, {wSubkeyValid, wRoundIndex, wSubkey});
      if (stall && stall_left > 0) begin
        wReady = 1'b0;
        stall_left--;
      end else begin
        wReady = 1'b1;
        if (stall && $urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 5);
      end
      if (poke && xfers == 5) begin
        wStart = 1'b1; wKey = ~drive_key; wDecrypt = ~dec;
      end else begin
        wStart = 1'b0;
      end
      if (wSubkeyValid && wReady) begin
        r = dec ? 15 - xfers : xfers;
        check($sformatf("subkey_%0d", xfers), wSubkey, ks[r]);
        check($sformatf("index_%0d", xfers), wRoundIndex, r);
        if (xfers == 0) begin first_sk = wSubkey; first_idx = wRoundIndex; end
        if (xfers == 15) begin last_sk = wSubkey; last_idx = wRoundIndex; end
        xfers++;
      end
      pval = wSubkeyValid; pidx = wRoundIndex; psk = wSubkey;
      pstall = wSubkeyValid && !wReady;
      tick();
      cyc++;
      if (abort_after != 0 && xfers == abort_after) begin
        wReset = 1'b1; wStart = 1'b0;
        tick();
        wReset = 1'b0;
        check("rst_mid_outputs", {wSubkey, wSubkeyValid, wRoundIndex, wBusy, wDone}, 64'h0);
        return;
      end
    end
    wStart = 1'b0; wReady = 1'b1;
    check("xfer_count", xfers, 16);
    check("no_early_done", dones_early, 0);
    check("done_pulse", {wDone, wSubkeyValid, wBusy}, 3'b100);
    if (restart_at_done) wStart = 1'b1;
    tick();
    check("done_once", {wDone, wSubkeyValid, wBusy}, 3'b000);
    if (restart_at_done) begin
      tick();
      wStart = 1'b0;
      check("restart_from_idle", {wSubkeyValid, wRoundIndex, wSubkey},
            {1'b1, dec ? 4'd15 : 4'd0, dec ? ks[15] : ks[0]});
      wReset = 1'b1;
      tick();
      wReset = 1'b0;
    end
  endtask

  initial begin
    wReset = 1'b1; wStart = 1'b1; wDecrypt = 1'b0; wReady = 1'b1; wKey = KEY;
    tick();
    tick();
    check("reset_state", {wSubkey, wSubkeyValid, wRoundIndex, wBusy, wDone}, 64'h0);
    wReset = 1'b0; wStart = 1'b0;
    tick();
    check("idle_no_start", {wSubkeyValid, wBusy, wDone}, 3'b000);

    // Encrypt, known-answer key
    run_seq(KEY, KEY, 1'b0, 0, 0, 0, 0);
    check("enc_first_sk", first_sk, 48'h1B02EFFC7072);
    check("enc_first_idx", first_idx, 4'd0);
    check("enc_last_sk", last_sk, 48'hCB3D8B0E17F5);
    check("enc_last_idx", last_idx, 4'd15);

    // Decrypt, known-answer key
    run_seq(KEY, KEY, 1'b1, 0, 0, 0, 0);
    check("dec_first_sk", first_sk, 48'hCB3D8B0E17F5);
    check("dec_first_idx", first_idx, 4'd15);
    check("dec_last_sk", last_sk, 48'h1B02EFFC7072);
    check("dec_last_idx", last_idx, 4'd0);

    // Decrypt under random backpressure
    run_seq(KEY, KEY, 1'b1, 1, 0, 0, 0);

    // Reset after the 7th transfer, then a clean sequence
    run_seq(KEY, KEY, 1'b0, 0, 0, 7, 0);
    run_seq(KEY, KEY, 1'b0, 0, 0, 0, 0);

    // Start pulse with a different key and direction mid-run
    run_seq(KEY, KEY, 1'b0, 0, 1, 0, 0);

    // Parity-bit-only key changes
    run_seq(KEY ^ 64'h1, KEY, 1'b0, 0, 0, 0, 0);
    run_seq(KEY ^ 64'h0101010101010101, KEY, 1'b1, 0, 0, 0, 0);

    // Random keys, random direction, random stalls
    for (int n = 0; n < 4; n++) begin
      logic [63:0] rk;
      rk = {$urandom, $urandom};
      run_seq(rk, rk, 1'($urandom_range(0, 1)), 1, n[0], 0, 0);
    end

    // Start held through DONE is accepted only once back in IDLE
    run_seq(KEY, KEY, 1'b1, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
